wakeup_release_pipeline: RTL and testbench

// - Consumer end of the wakeup/select loop: takes per-lane grants from the select logic and, after
//   a per-op latency, drives the wakeup ports (ptr + one-hot vector) back into the wakeup logic.
// - Also drives issue-queue entry release a fixed number of cycles after selection.
// - One shift pipeline per issue lane; holds on stall, clears on flush.

---
 rtl/wakeup_release_pipeline.sv | 130 +++++++++++++
 tb/tb_wakeup_release_pipeline.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wakeup_release_pipeline.sv
// Wakeup/release pipeline: the consumer end of the wakeup/select loop.
// Each issue lane keeps a wakeup shift register (one slot per latency cycle)
// and a release shift register. A granted op is inserted at the slot matching
// its latency. It then walks toward slot 0, which drives the registered
// wakeup and release ports.
module wakeup_release_pipeline #(
  parameter int ISSUE_WIDTH  = 4,
  parameter int IQ_ENTRY_NUM = 16,
  parameter int MAX_LAT      = 4,
  parameter int RELEASE_LAT  = 2,
  localparam int IDX_W       = $clog2(IQ_ENTRY_NUM),
  localparam int LAT_W       = $clog2(MAX_LAT + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      stall,
  input  logic                                      flush,
  input  logic [ISSUE_WIDTH-1:0]                    selected,
  input  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]         selectedPtr,
  input  logic [ISSUE_WIDTH-1:0][IQ_ENTRY_NUM-1:0]  selectedVector,
  input  logic [ISSUE_WIDTH-1:0][LAT_W-1:0]         selLatency,
  output logic [ISSUE_WIDTH-1:0]                    wakeup,
  output logic [ISSUE_WIDTH-1:0][IDX_W-1:0]         wakeupPtr,
  output logic [ISSUE_WIDTH-1:0][IQ_ENTRY_NUM-1:0]  wakeupVector,
  output logic [ISSUE_WIDTH-1:0]                    releaseEntry,
  output logic [ISSUE_WIDTH-1:0][IDX_W-1:0]         releasePtr,
  output logic [ISSUE_WIDTH-1:0]                    latencyConflict
);

  // Current pipeline state: the valid bits and the payload are kept apart.
  logic [MAX_LAT-1:0]     wValid [ISSUE_WIDTH];
  logic [IDX_W-1:0]       wPtr   [ISSUE_WIDTH][MAX_LAT];
  logic [IQ_ENTRY_NUM-1:0] wVec  [ISSUE_WIDTH][MAX_LAT];
  logic [RELEASE_LAT-1:0] rValid [ISSUE_WIDTH];
  logic [IDX_W-1:0]       rPtr   [ISSUE_WIDTH][RELEASE_LAT];

  // State after the shift and the insertion on an ordinary cycle.
  logic [MAX_LAT-1:0]     nwValid [ISSUE_WIDTH];
  logic [IDX_W-1:0]       nwPtr   [ISSUE_WIDTH][MAX_LAT];
  logic [IQ_ENTRY_NUM-1:0] nwVec  [ISSUE_WIDTH][MAX_LAT];
  logic [RELEASE_LAT-1:0] nrValid [ISSUE_WIDTH];
  logic [IDX_W-1:0]       nrPtr   [ISSUE_WIDTH][RELEASE_LAT];
  logic [ISSUE_WIDTH-1:0] conflict;

  // Clamp the requested latency into the range 1..MAX_LAT.
  function automatic logic [LAT_W-1:0] clampLat(input logic [LAT_W-1:0] lat);
    if (lat == '0)                  return LAT_W'(1);
    else if (lat > LAT_W'(MAX_LAT)) return LAT_W'(MAX_LAT);
    else                            return lat;
  endfunction

  // Shift every lane toward slot 0, then insert the new grant at slot L-1.
  always_comb begin
    // NOTE: every output of this block gets a default before any condition, so no latch is inferred.
    int slot;
    slot     = 0;
    conflict = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      nwValid[i] = wValid[i] >> 1;
      for (int k = 0; k < MAX_LAT - 1; k++) begin
        nwPtr[i][k] = wPtr[i][k+1];
        nwVec[i][k] = wVec[i][k+1];
      end
      nwPtr[i][MAX_LAT-1] = '0;
      nwVec[i][MAX_LAT-1] = '0;

      nrValid[i] = rValid[i] >> 1;
      for (int k = 0; k < RELEASE_LAT - 1; k++) nrPtr[i][k] = rPtr[i][k+1];
      nrPtr[i][RELEASE_LAT-1] = '0;

      slot = int'(clampLat(selLatency[i])) - 1;
      if (selected[i]) begin
        // An occupied target slot keeps the older op and raises the error flag.
        if (nwValid[i][slot]) begin
          conflict[i] = 1'b1;
        end else begin
          nwValid[i][slot] = 1'b1;
          nwPtr[i][slot]   = selectedPtr[i];
          nwVec[i][slot]   = selectedVector[i];
        end
        nrValid[i][RELEASE_LAT-1] = 1'b1;
        nrPtr[i][RELEASE_LAT-1]   = selectedPtr[i];
      end
    end
  end

  // Update the valid bits and the registered outputs (reset/flush, stall, normal).
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments, so the order of the statements does not affect the result.
    if (rst || flush) begin
      wValid          <= '{default: '0};
      rValid          <= '{default: '0};
      wakeup          <= '0;
      wakeupPtr       <= '0;
      wakeupVector    <= '0;
      releaseEntry    <= '0;
      releasePtr      <= '0;
      latencyConflict <= '0;
    end else if (stall) begin
      wakeup          <= '0;
      wakeupPtr       <= '0;
      wakeupVector    <= '0;
      releaseEntry    <= '0;
      releasePtr      <= '0;
      latencyConflict <= '0;
    end else begin
      wValid          <= nwValid;
      rValid          <= nrValid;
      latencyConflict <= conflict;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        wakeup[i]       <= nwValid[i][0];
        wakeupPtr[i]    <= nwValid[i][0] ? nwPtr[i][0] : '0;
        wakeupVector[i] <= nwValid[i][0] ? nwVec[i][0] : '0;
        releaseEntry[i] <= nrValid[i][0];
        releasePtr[i]   <= nrValid[i][0] ? nrPtr[i][0] : '0;
      end
    end
  end

  // Payload follows the shift and is frozen by stall.
  always_ff @(posedge clk) begin
    // NOTE: the payload storage has no reset; the valid bits alone decide whether a slot counts.
    if (!stall) begin
      wPtr <= nwPtr;
      wVec <= nwVec;
      rPtr <= nrPtr;
    end
  end

endmodule

// File: tb/tb_wakeup_release_pipeline.sv
// Directed bench for wakeup_release_pipeline. Expected wakeup, release and
// conflict events go onto a scoreboard queue, tagged with the cycle in which
// they must appear. Every cycle the bench takes off the events due and
// compares every lane's outputs against them.
module tb_wakeup_release_pipeline;

  localparam int NL = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stall;
  logic                  flush;
  logic [NL-1:0]         selected;
  logic [NL-1:0][3:0]    selectedPtr;
  logic [NL-1:0][15:0]   selectedVector;
  logic [NL-1:0][2:0]    selLatency;
  logic [NL-1:0]         wakeup;
  logic [NL-1:0][3:0]    wakeupPtr;
  logic [NL-1:0][15:0]   wakeupVector;
  logic [NL-1:0]         releaseEntry;
  logic [NL-1:0][3:0]    releasePtr;
  logic [NL-1:0]         latencyConflict;

  wakeup_release_pipeline dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .selected(selected), .selectedPtr(selectedPtr),
    .selectedVector(selectedVector), .selLatency(selLatency),
    .wakeup(wakeup), .wakeupPtr(wakeupPtr), .wakeupVector(wakeupVector),
    .releaseEntry(releaseEntry), .releasePtr(releasePtr),
    .latencyConflict(latencyConflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_WAKE, EV_REL, EV_CONF} ev_kind_e;
  typedef struct {
    int       at;
    int       lane;
    ev_kind_e kind;
    int       ptr;
  } ev_t;
  ev_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind, input int lane, input int ptr, input int at);
    ev_t e;
    e.at = at; e.lane = lane; e.kind = kind; e.ptr = ptr;
    sb.push_back(e);
  endtask

  // Take off the events due this cycle and compare all lanes against them.
  task automatic compare_outputs();
    bit ew[NL]; bit er[NL]; bit ec[NL];
    int ewp[NL]; int erp[NL];
    for (int i = 0; i < NL; i++) begin
      ew[i] = 0; er[i] = 0; ec[i] = 0; ewp[i] = 0; erp[i] = 0;
    end
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].at == cyc) begin
        case (sb[j].kind)
          EV_WAKE: begin ew[sb[j].lane] = 1; ewp[sb[j].lane] = sb[j].ptr; end
          EV_REL:  begin er[sb[j].lane] = 1; erp[sb[j].lane] = sb[j].ptr; end
          default: ec[sb[j].lane] = 1;
        endcase
        sb.delete(j);
      end
    end
    for (int i = 0; i < NL; i++) begin
      check($sformatf("wakeup[%0d]", i), 32'(wakeup[i]), 32'(ew[i]));
      check($sformatf("releaseEntry[%0d]", i), 32'(releaseEntry[i]), 32'(er[i]));
      check($sformatf("latencyConflict[%0d]", i), 32'(latencyConflict[i]), 32'(ec[i]));
      if (ew[i]) begin
        check($sformatf("wakeupPtr[%0d]", i), 32'(wakeupPtr[i]), 32'(ewp[i]));
        check($sformatf("wakeupVector[%0d]", i), 32'(wakeupVector[i]), 32'h1 << ewp[i]);
      end
      if (er[i]) check($sformatf("releasePtr[%0d]", i), 32'(releasePtr[i]), 32'(erp[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_inputs();
    selected = '0; selectedPtr = '0; selectedVector = '0; selLatency = '0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic grant(input int lane, input int ptr, input int lat);
    selected[lane]       = 1'b1;
    selectedPtr[lane]    = 4'(ptr);
    selectedVector[lane] = 16'h1 << ptr;
    selLatency[lane]     = 3'(lat);
  endtask

  initial begin
    int c;
    clear_inputs();
    rst = 1'b1;

    // Reset for three cycles: every flag must be low.
    idle(3);
    rst = 1'b0;
    idle(2);

    // Lane 0, L=1: wakeup in the next cycle, release two cycles after the grant.
    c = cyc;
    grant(0, 5, 1);
    expect_ev(EV_WAKE, 0, 5, c + 1);
    expect_ev(EV_REL,  0, 5, c + 2);
    tick(); clear_inputs(); idle(4);

    // Lane 1: L=3 then L=1 one cycle later; the two wakeups land in different slots.
    c = cyc;
    grant(1, 3, 3);
    expect_ev(EV_WAKE, 1, 3, c + 3);
    expect_ev(EV_REL,  1, 3, c + 2);
    tick();
    clear_inputs();
    grant(1, 7, 1);
    expect_ev(EV_WAKE, 1, 7, c + 2);
    expect_ev(EV_REL,  1, 7, c + 3);
    tick(); clear_inputs(); idle(4);

    // Lane 2: L=2 then L=1 collide; the older op wins and the conflict flag rises.
    c = cyc;
    grant(2, 1, 2);
    expect_ev(EV_WAKE, 2, 1, c + 2);
    expect_ev(EV_REL,  2, 1, c + 2);
    tick();
    clear_inputs();
    grant(2, 4, 1);
    expect_ev(EV_CONF, 2, 0, c + 2);
    expect_ev(EV_REL,  2, 4, c + 3);
    tick(); clear_inputs(); idle(4);

    // Lane 3, L=4, stall for three cycles: both wakeup and release are delayed by 3.
    c = cyc;
    grant(3, 9, 4);
    expect_ev(EV_WAKE, 3, 9, c + 7);
    expect_ev(EV_REL,  3, 9, c + 5);
    tick();
    clear_inputs(); stall = 1'b1;
    tick();
    grant(0, 6, 1);          // grant during stall must be ignored
    tick();
    clear_inputs(); stall = 1'b1;
    tick();
    clear_inputs(); idle(6);

    // Latency clamping plus simultaneous lanes: 0 acts as 1, 7 acts as MAX_LAT=4.
    c = cyc;
    grant(0, 2, 0);
    grant(1, 15, 7);
    expect_ev(EV_WAKE, 0, 2,  c + 1);
    expect_ev(EV_REL,  0, 2,  c + 2);
    expect_ev(EV_WAKE, 1, 15, c + 4);
    expect_ev(EV_REL,  1, 15, c + 2);
    tick(); clear_inputs(); idle(5);

    // All lanes grant with L=2, then a flush: nothing may come out.
    for (int i = 0; i < NL; i++) grant(i, 10 + i, 2);
    tick();
    clear_inputs(); flush = 1'b1;
    grant(0, 8, 1);          // same-cycle grant is dropped by flush
    tick(); clear_inputs(); idle(5);

    // Flush together with stall still clears the pipeline.
    grant(3, 12, 3);
    tick();
    clear_inputs(); flush = 1'b1; stall = 1'b1;
    tick(); clear_inputs(); idle(5);

    check("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
